// File: rtl/ldm_seq_pkg.sv
// ldm_seq_pkg: shared state encoding, P/U addressing mode constants and popcount16 helper
package ldm_seq_pkg;
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;
  localparam logic [1:0] MODE_DA = 2'b00;
  localparam logic [1:0] MODE_IA = 2'b01;
  localparam logic [1:0] MODE_DB = 2'b10;
  localparam logic [1:0] MODE_IB = 2'b11;
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    popcount16 = '0;
    for (int i = 0; i < 16; i++) popcount16 += {4'b0, v[i]};
  endfunction
endpackage

// File: rtl/lsb_enc16.sv
// lsb_enc16: lowest-set-bit encoder, vec -> idx (index of lowest 1) and vld (any bit set)
module lsb_enc16 (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        vld
);
  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--) idx = vec[i] ? 4'(i) : idx;
  end
  assign vld = |vec;
endmodule

// File: rtl/ldm_seq.sv
// ldm_seq: LDM/STM block-transfer sequencer; i_start/i_reglist/i_base/i_p/i_u/i_w/i_l in, one register transfer per accepted cycle out with base writeback and pipeline hold
module ldm_seq
  import ldm_seq_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_reglist,
  input  logic [3:0]  i_rn_code,
  input  logic [31:0] i_base,
  input  logic        i_p,
  input  logic        i_u,
  input  logic        i_w,
  input  logic        i_l,
  input  logic        i_stall,
  output logic        o_ldm_hold,
  output logic        o_vld,
  output logic [3:0]  o_reg_code,
  output logic [31:0] o_addr,
  output logic        o_load,
  output logic        o_last,
  output logic        o_wb_en,
  output logic [31:0] o_wb_data,
  output logic        o_busy
);
  state_t      state, state_n;
  logic [15:0] list;
  logic [4:0]  cnt, n;
  logic [31:0] n4, start_addr;
  logic        wb, base_in, start, idx_vld;
  lsb_enc16 u_enc (.vec(list), .idx(o_reg_code), .vld(idx_vld));
  assign n = popcount16(i_reglist);
  assign n4 = {25'b0, n, 2'b0};
  assign start = state == IDLE && i_start && |i_reglist;
  assign start_addr = {i_p, i_u} == MODE_IA ? i_base :
                      {i_p, i_u} == MODE_IB ? i_base + 32'd4 :
                      {i_p, i_u} == MODE_DA ? i_base - n4 + 32'd4 : i_base - n4;
  always_comb begin
    o_busy = state == XFER;
    o_vld = o_busy && idx_vld;
    o_last = o_vld && cnt == 5'd1;
    o_ldm_hold = o_busy && !(o_last && !i_stall);
    o_wb_en = o_last && !i_stall && wb && !(o_load && base_in);
    state_n = start ? XFER : (o_last && !i_stall) ? IDLE : state;
  end
  // the final list bit and address are left in place so o_reg_code/o_addr hold their last values in IDLE
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      list <= '0;
      cnt <= '0;
      o_addr <= '0;
      o_wb_data <= '0;
      o_load <= 1'b0;
      wb <= 1'b0;
      base_in <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        list <= i_reglist;
        cnt <= n;
        o_addr <= start_addr;
        o_wb_data <= i_u ? i_base + n4 : i_base - n4;
        o_load <= i_l;
        wb <= i_w;
        base_in <= i_reglist[i_rn_code];
      end else if (o_vld && !i_stall && !o_last) begin
        list[o_reg_code] <= 1'b0;
        cnt <= cnt - 5'd1;
        o_addr <= o_addr + 32'd4;
      end
    end
  end
endmodule

// File: doc/ldm_seq.md
LDM_SEQ -- requirements
Module: ldm_seq

Interface
REQ-001 SHALL have clock and reset ports: i_clk in 1, rising-edge clock; i_rst in 1, reset, synchronous and active-high.
REQ-002 SHALL have i_start in 1, ID-phase block-transfer (LDM/STM) accepted this cycle.
REQ-003 SHALL have i_reglist in 16, register list, bit k = Rk.
REQ-004 SHALL have i_rn_code in 4, base register number.
REQ-005 SHALL have i_base in 32, base register value.
REQ-006 SHALL have i_p, i_u, i_w, i_l in 1 each: pre-index, up, writeback, load.
REQ-007 SHALL have i_stall in 1, memory not ready; the current transfer is not accepted.
REQ-008 SHALL have o_ldm_hold out 1, pipeline hold to the hazard controller.
REQ-009 SHALL have o_vld out 1, transfer valid.
REQ-010 SHALL have o_reg_code out 4, register for this transfer.
REQ-011 SHALL have o_addr out 32, word address for this transfer.
REQ-012 SHALL have o_load out 1, latched i_l.
REQ-013 SHALL have o_last out 1, final transfer.
REQ-014 SHALL have o_wb_en out 1, base writeback strobe.
REQ-015 SHALL have o_wb_data out 32, new base value.
REQ-016 SHALL have o_busy out 1, high when not IDLE.

Function
REQ-017 SHALL implement two states, IDLE and XFER.
REQ-018 IDLE: i_start with i_reglist!=0 -> latch all inputs, count n=popcount(i_reglist), go to XFER next cycle.
REQ-019 SHALL ignore i_start with i_reglist==0: no transfer, no hold, no writeback.
REQ-020 SHALL ignore i_start while in XFER.
REQ-021 Start address (modulo 2^32): IA (P=0,U=1) = base; IB (P=1,U=1) = base+4; DA (P=0,U=0) = base-4n+4; DB (P=1,U=0) = base-4n.
REQ-022 XFER: o_vld=1 every cycle; o_reg_code = lowest set bit of the remaining list; o_addr = current address.
REQ-023 A transfer is accepted when o_vld && !i_stall; then clear that list bit and advance the address by 4.
REQ-024 i_stall=1 SHALL freeze state, list, address and all outputs.
REQ-025 o_last=1 when exactly one list bit remains.
REQ-026 Accepting the transfer with o_last=1 -> return to IDLE next cycle.
REQ-027 Transfer latency: first transfer one cycle after the start cycle; n transfers take n cycles with no stall, n+k cycles with k stall cycles.
REQ-028 o_ldm_hold = XFER && !(o_last && !i_stall); the pipeline resumes in the cycle after the final accepted transfer.
REQ-029 o_wb_en = o_last && !i_stall && W && !(L && base in list); the load value wins over base writeback.
REQ-030 o_wb_data = base+4n if U=1, base-4n if U=0, computed at start.
REQ-031 Outside XFER: o_vld, o_last, o_wb_en, o_ldm_hold SHALL be 0; o_reg_code, o_addr, o_wb_data SHALL hold their last values.

Reset
REQ-032 i_rst SHALL force IDLE, clear the list and count, and drive all outputs to 0 on the next edge.
REQ-033 i_rst during XFER SHALL abort with no further transfer and no writeback.
REQ-034 i_rst SHALL take priority over i_start in the same cycle.

Structure
REQ-035 A shared package SHALL hold the state encoding (IDLE=0, XFER=1), the P/U mode constants and a popcount16 function.
REQ-036 One sub-module SHALL be instantiated: lsb_enc16, a 16-bit lowest-set-bit encoder giving a 4-bit index and a valid flag.
REQ-037 SHALL contain no other memories or multi-cycle arithmetic.

Verification
REQ-038 LDMIA, base 0x1000, list 0x000E, W=1, no stall -> transfers R1@0x1000, R2@0x1004, R3@0x1008 in consecutive cycles; hold high for 2 cycles; o_wb_en with 0x100C on the R3 cycle.
REQ-039 STMDB, base 0x2000, list 0x4010, W=1 -> R4@0x1FF8, R14@0x1FFC; wb 0x1FF8.
REQ-040 LDMIB, base 0x0, list 0x0001, i_stall high 3 cycles -> R0@0x4 held for 4 cycles; o_last=1, o_ldm_hold=0 only in the accepted cycle.
REQ-041 LDMDA, Rn=R5, base 0x100, list 0x0021, W=1 -> R0@0xFC, R5@0x100; o_wb_en never asserts.
REQ-042 i_rst asserted on the 2nd transfer of list 0xFFFF -> next cycle IDLE, all outputs 0, no wb.
REQ-043 i_start with list 0x0000 -> o_busy stays 0; i_start during XFER -> sequence unaffected.
